move_sequencer: RTL and testbench



---
 rtl/move_sequencer.sv | 138 +++++++++++++
 tb/tb_move_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// move_sequencer: clamps host position commands and issues them to the motor-control block as bounded segments
module move_sequencer #(
  parameter logic signed [31:0] POS_MIN = -32'sd1000000,
  parameter logic signed [31:0] POS_MAX = 32'sd1000000,
  parameter logic [19:0] VEL_DIV_MIN = 20'h00115,
  parameter logic [19:0] VEL_DIV_MAX = 20'h1E848,
  parameter logic [15:0] SEG_MAX = 16'hFFFF,
  parameter int unsigned START_TIMEOUT = 1000,
  parameter int unsigned SETTLE_CYCLES = 50000
) (
  input  logic        CLK_50MHZ,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_target,
  input  logic [19:0] cmd_vel_div,
  input  logic        abort,
  input  logic [31:0] cur_position,
  input  logic        mc_busy,
  output logic        mc_start,
  output logic        mc_dir,
  output logic [15:0] mc_delta,
  output logic [19:0] mc_vel_div,
  output logic        done,
  output logic        clamped,
  output logic        fault
);
  typedef enum logic [3:0] {IDLE, CALC, ISSUE, WAIT_BUSY, WAIT_DONE, SETTLE, DONE, DRAIN, FAULT} state_t;
  state_t state_q, state_d;
  logic signed [31:0] tgt_q, tgt_d;
  logic [19:0] div_q, div_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] tmr_q, tmr_d;
  logic cmd_ready_q, cmd_ready_d, mc_start_q, mc_start_d, mc_dir_q, mc_dir_d;
  logic done_q, done_d, clamped_q, clamped_d, fault_q, fault_d;
  logic [15:0] mc_delta_q, mc_delta_d;
  logic [19:0] mc_vel_div_q, mc_vel_div_d;
  logic accept;
  logic [32:0] diff, mag;
  logic [15:0] seg;
  // next-state and registered-output computation; abort overrides whatever the state decided
  always_comb begin
    accept = state_q == IDLE && cmd_ready_q && cmd_valid && !abort;
    diff = {tgt_q[31], tgt_q} - {cur_position[31], cur_position};
    mag = diff[32] ? -diff : diff;
    seg = rem_q > {17'd0, SEG_MAX} ? SEG_MAX : rem_q[15:0];
    state_d = state_q;
    tgt_d = tgt_q;
    div_d = div_q;
    rem_d = rem_q;
    tmr_d = tmr_q + 32'd1;
    mc_dir_d = mc_dir_q;
    clamped_d = clamped_q;
    mc_start_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = CALC;
        tgt_d = $signed(cmd_target) < POS_MIN ? POS_MIN : $signed(cmd_target) > POS_MAX ? POS_MAX : $signed(cmd_target);
        div_d = cmd_vel_div < VEL_DIV_MIN ? VEL_DIV_MIN : cmd_vel_div > VEL_DIV_MAX ? VEL_DIV_MAX : cmd_vel_div;
        clamped_d = tgt_d != $signed(cmd_target) || div_d != cmd_vel_div;
      end
      CALC: begin
        state_d = diff == '0 ? DONE : ISSUE;
        mc_dir_d = diff == '0 ? mc_dir_q : !diff[32];
        rem_d = mag;
      end
      ISSUE: if (!mc_busy) begin
        state_d = WAIT_BUSY;
        mc_start_d = 1'b1;
        rem_d = rem_q - {17'd0, seg};
        tmr_d = '0;
      end
      WAIT_BUSY: state_d = mc_busy ? WAIT_DONE : tmr_q == START_TIMEOUT - 1 ? FAULT : WAIT_BUSY;
      WAIT_DONE: if (!mc_busy) begin
        state_d = SETTLE;
        tmr_d = '0;
      end
      SETTLE: if (tmr_q == SETTLE_CYCLES - 1) state_d = rem_q != '0 ? ISSUE : DONE;
      DONE: begin
        state_d = IDLE;
        done_d = 1'b1;
      end
      DRAIN: if (!mc_busy) state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (abort && state_q != IDLE) begin
      rem_d = '0;
      mc_start_d = 1'b0;
      done_d = 1'b0;
      state_d = (state_q == WAIT_BUSY || state_q == WAIT_DONE || (state_q == DRAIN && mc_busy)) ? DRAIN : IDLE;
    end
    mc_delta_d = mc_start_d ? seg : mc_delta_q;
    mc_vel_div_d = mc_start_d ? div_q : mc_vel_div_q;
    cmd_ready_d = state_q == IDLE && !accept;
    fault_d = state_q == FAULT && !abort;
  end
  // state and all outputs registered together
  always_ff @(posedge CLK_50MHZ or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q <= '0;
      div_q <= VEL_DIV_MAX;
      rem_q <= '0;
      tmr_q <= '0;
      cmd_ready_q <= 1'b0;
      mc_start_q <= 1'b0;
      mc_dir_q <= 1'b0;
      mc_delta_q <= '0;
      mc_vel_div_q <= VEL_DIV_MAX;
      done_q <= 1'b0;
      clamped_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      div_q <= div_d;
      rem_q <= rem_d;
      tmr_q <= tmr_d;
      cmd_ready_q <= cmd_ready_d;
      mc_start_q <= mc_start_d;
      mc_dir_q <= mc_dir_d;
      mc_delta_q <= mc_delta_d;
      mc_vel_div_q <= mc_vel_div_d;
      done_q <= done_d;
      clamped_q <= clamped_d;
      fault_q <= fault_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign mc_start = mc_start_q;
  assign mc_dir = mc_dir_q;
  assign mc_delta = mc_delta_q;
  assign mc_vel_div = mc_vel_div_q;
  assign done = done_q;
  assign clamped = clamped_q;
  assign fault = fault_q;
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: random and directed moves checked against a segment-list reference model
module tb_move_sequencer;
  localparam int ST = 30;
  localparam int SC = 20;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, abort = 1'b0, mc_busy = 1'b0;
  logic [31:0] cmd_target = '0, cur_position = '0;
  logic [19:0] cmd_vel_div = '0;
  logic cmd_ready, mc_start, mc_dir, done, clamped, fault;
  logic [15:0] mc_delta;
  logic [19:0] mc_vel_div;
  int n_chk = 0, n_pass = 0, n_start = 0, n_done = 0, n_clash = 0;
  int n, s0, d0;

  move_sequencer #(.START_TIMEOUT(ST), .SETTLE_CYCLES(SC)) dut (
    .CLK_50MHZ(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_vel_div(cmd_vel_div), .abort(abort),
    .cur_position(cur_position), .mc_busy(mc_busy), .mc_start(mc_start),
    .mc_dir(mc_dir), .mc_delta(mc_delta), .mc_vel_div(mc_vel_div),
    .done(done), .clamped(clamped), .fault(fault));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mc_start) n_start++;
    if (done) n_done++;
    if (mc_start && mc_busy) n_clash++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // reference: clamp, then split |target-cur| into SEG_MAX-sized chunks
  task automatic run_move(input int tgt, input logic [19:0] vel, input int cur);
    longint ct, d, mag;
    logic [19:0] cv;
    int segs[$];
    int k, a0, b0;
    ct = tgt < -1000000 ? -1000000 : (tgt > 1000000 ? 1000000 : tgt);
    cv = vel < 20'h00115 ? 20'h00115 : (vel > 20'h1E848 ? 20'h1E848 : vel);
    d = ct - cur;
    mag = d < 0 ? -d : d;
    while (mag > 0) begin
      segs.push_back(mag > 65535 ? 65535 : int'(mag));
      mag -= segs[$];
    end
    cur_position = cur;
    k = 0;
    while (!cmd_ready && k < 50) begin tick(); k++; end
    check("ready_idle", cmd_ready, 1);
    a0 = n_start;
    b0 = n_done;
    cmd_target = tgt;
    cmd_vel_div = vel;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("ready_drop", cmd_ready, 0);
    check("clamped", clamped, (ct != tgt || cv != vel));
    tick();
    tick();
    check("start_lat", mc_start, segs.size() != 0);
    foreach (segs[i]) begin
      check("dir", mc_dir, d > 0);
      check("delta", mc_delta, segs[i]);
      check("vdiv", mc_vel_div, cv);
      tick();
      check("start_pulse", mc_start, 0);
      repeat ($urandom_range(0, 2)) tick();
      mc_busy = 1'b1;
      repeat ($urandom_range(2, 6)) tick();
      mc_busy = 1'b0;
      k = 0;
      do begin tick(); k++; end while (!mc_start && !done && k < 200);
      check("gap", k, SC + 2);
      check("gap_kind", mc_start, i != segs.size() - 1);
    end
    check("done_pulse", done, 1);
    check("starts", n_start - a0, segs.size());
    tick();
    check("done_once", done, 0);
    check("ready_back", cmd_ready, 1);
    check("dones", n_done - b0, 1);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_ready", cmd_ready, 0);
    check("rst_start", mc_start, 0);
    check("rst_vdiv", mc_vel_div, 20'h1E848);
    check("rst_fault", fault, 0);
    rst = 1'b0;
    tick();
    check("ready_rise", cmd_ready, 1);

    run_move(1000, 20'h01000, 0);
    run_move(150000, 20'h01000, 0);
    run_move(2000000, 20'h00010, 0);
    run_move(-500, 20'h02000, -500);
    run_move(-3000000, 20'hFFFFF, 5000);
    for (int r = 0; r < 6; r++)
      run_move(int'($urandom_range(0, 4400000)) - 2200000, 20'($urandom_range(0, 20'hFFFFF)),
               int'($urandom_range(0, 400000)) - 200000);

    cur_position = 0;
    cmd_target = 1000;
    cmd_vel_div = 20'h01000;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("to_start", mc_start, 1);
    n = 0;
    do begin tick(); n++; end while (!fault && n < 200);
    check("to_lat", n, ST + 1);
    check("to_ready", cmd_ready, 0);
    repeat (3) tick();
    check("to_sticky", fault, 1);
    abort = 1'b1;
    tick();
    check("abort_fault", fault, 0);
    abort = 1'b0;
    tick();
    check("abort_ready", cmd_ready, 1);

    s0 = n_start;
    d0 = n_done;
    cmd_target = 150000;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("ab_start", mc_start, 1);
    tick();
    mc_busy = 1'b1;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (4) tick();
    check("ab_drain", cmd_ready, 0);
    mc_busy = 1'b0;
    tick();
    tick();
    check("ab_ready", cmd_ready, 1);
    repeat (SC + 10) tick();
    check("ab_nostart", n_start - s0, 1);
    check("ab_nodone", n_done - d0, 0);

    cmd_target = 150000;
    cmd_vel_div = 20'h00010;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("rs_start", mc_start, 1);
    tick();
    mc_busy = 1'b1;
    repeat (2) tick();
    mc_busy = 1'b0;
    repeat (5) tick();
    check("rs_pre_delta", mc_delta, 65535);
    rst = 1'b1;
    #1;
    check("rs_ready", cmd_ready, 0);
    check("rs_start0", mc_start, 0);
    check("rs_dir", mc_dir, 0);
    check("rs_delta", mc_delta, 0);
    check("rs_vdiv", mc_vel_div, 20'h1E848);
    check("rs_done", done, 0);
    check("rs_clamped", clamped, 0);
    check("rs_fault", fault, 0);
    #3;
    rst = 1'b0;
    tick();
    check("rs_ready_rise", cmd_ready, 1);
    check("start_busy", n_clash, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
